button_conditioner: RTL
=======================

# button_conditioner

Front-end stage that turns the five raw board pushbuttons into the clean, single-cycle `btn*_v` strobes consumed by the `game` block. Each button is synchronised, debounced by a consecutive-sample counter, and converted into pulses: directional buttons auto-repeat while held, and the centre button fires once per press. It sits between the board pins and `game`, in the `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000, consecutive identical synchronised samples required to accept a level change (≥2)
- `REPEAT_CYCLES`, default 2000000, period in clocks between auto-repeat strobes on a held directional button (≥2)
- `clk  in  1  system clock; all state updates on rising edge`
- `rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low`
- `btnl, btnd, btnr, btnu, btns  in  1 each  raw asynchronous pushbutton levels, 1 = pressed`
- `btnl_v, btnd_v, btnr_v, btnu_v, btns_v  out  1 each  registered one-cycle strobes to `game``
- `btn_held  out  5  debounced levels {btns,btnu,btnr,btnd,btnl} (bit 0 = l)`

## Operation
- Per button, independent channel: 2-FF synchroniser -> debounce -> strobe logic.
- Debounce: counter `cnt` (width ceil(log2(DEBOUNCE_CYCLES))+1). Each edge: if synchronised sample == `stable`, `cnt`←0; else `cnt`←`cnt`+1, and when `cnt` == DEBOUNCE_CYCLES-1 then `stable`←sample, `cnt`←0. A glitch shorter than DEBOUNCE_CYCLES samples never changes `stable`.
- `btn_held` = `stable` vector, registered.
- Press (stable 0->1): strobe asserted in the same edge `stable` rises; repeat counter `rpt`←0.
- Held directional (l/d/r/u): `rpt` increments every cycle; at `rpt` == REPEAT_CYCLES-1 strobe asserts and `rpt`←0. Pulses therefore at press, then every REPEAT_CYCLES clocks.
- Centre `btns`: strobe only on press; no repeat.
- Release (stable 1->0): no strobe; `rpt` held at 0.
- Opposing-direction lockout: while `stable` l and r are both 1, `btnl_v` and `btnr_v` are forced 0; same for u and d. `rpt` counters keep running; strobes resume on the next repeat point after lockout ends (no catch-up pulse).
- Different non-opposing buttons are fully independent; simultaneous strobes allowed.

## Timing
- Reset (async assert): all synchroniser flops, `stable`, `cnt`, `rpt` ← 0; all `btn*_v` ← 0; `btn_held` ← 0. Deassertion takes effect on the next rising edge.
- Latency: raw input first sampled high at edge k and held -> `stable` and strobe assert after edge k+1+DEBOUNCE_CYCLES; strobe low after the following edge.
- Release latency same: `btn_held` bit clears after edge k+1+DEBOUNCE_CYCLES.
- Strobe width exactly one clock; never two consecutive cycles high.
- Reset mid-hold: outputs clear immediately; a button still held after reset is treated as a new press (full debounce, then strobe).
- Counters saturate never: `cnt` and `rpt` always reset on match, no wrap beyond terminal value.

## Test plan
- DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8; raise `btnl` sampled at edge 10, hold -> `btnl_v` high only in cycle after edge 15, then after edges 23, 31, 39; `btn_held[0]`=1 from edge 15.
- Glitch: `btnr` high for 3 clocks then low -> `btnr_v` never asserts, `btn_held[2]` stays 0; high for 4 samples -> one strobe.
- Hold `btns` 50 clocks -> exactly one `btns_v` pulse; release and re-press -> second pulse.
- Hold `btnl`, then add `btnr` -> after `btnr` debounces, neither `btnl_v` nor `btnr_v` pulses; release `btnr` -> `btnl_v` resumes at its next repeat point; `btnu` held concurrently strobes unaffected.
- Assert `rst_n`=0 while `btnd` held with strobes running -> `btnd_v`, `btn_held` 0 asynchronously; release reset -> `btnd_v` pulses 5 edges later (DEBOUNCE 4 + sync).
- Bounce train (alternating 1/0 each clock for 20 clocks, then 1) -> single strobe 5 edges after final stable high sample.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions five raw pushbuttons into debounced levels and one-cycle strobes for the game block.
// Latency: strobe and btn_held follow a raw press by 2 sync + DEBOUNCE_CYCLES clocks.
// No backpressure: strobes are fire-and-forget; directional buttons auto-repeat while held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnl,
    input  logic       btnd,
    input  logic       btnr,
    input  logic       btnu,
    input  logic       btns,
    output logic       btnl_v,
    output logic       btnd_v,
    output logic       btnr_v,
    output logic       btnu_v,
    output logic       btns_v,
    output logic [4:0] btn_held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST    = RW'(REPEAT_CYCLES - 1);
    // Bit order {s,u,r,d,l}; only the centre button is excluded from auto-repeat.
    localparam logic [4:0]    REPEAT_MASK = 5'b01111;

    logic [4:0] raw;
    logic [4:0] sync1;
    logic [4:0] sync2;
    logic [4:0] stable;
    logic [4:0] stable_nxt;
    logic [4:0] press;
    logic [4:0] rpt_hit;
    logic [4:0] strobe;
    logic       lock_lr;
    logic       lock_ud;

    assign raw = {btns, btnu, btnr, btnd, btnl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_chan
        logic [CW-1:0] cnt;
        logic [RW-1:0] rpt;
        logic          stb;
        logic          accept;

        assign accept        = (sync2[i] != stb) && (cnt == CNT_LAST);
        assign stable[i]     = stb;
        assign stable_nxt[i] = accept ? sync2[i] : stb;
        assign press[i]      = accept && sync2[i];
        assign rpt_hit[i]    = REPEAT_MASK[i] && stb && stable_nxt[i] && (rpt == RPT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                rpt <= '0;
                stb <= 1'b0;
            end else begin
                if ((sync2[i] == stb) || accept) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                stb <= stable_nxt[i];
                // Repeat phase keeps running through lockout so no catch-up pulse appears.
                if (press[i] || !stable_nxt[i] || rpt_hit[i]) begin
                    rpt <= '0;
                end else begin
                    rpt <= rpt + 1'b1;
                end
            end
        end
    end

    // Lockout looks at next-state levels so it lines up with btn_held on the same edge.
    assign lock_lr = stable_nxt[0] & stable_nxt[2];
    assign lock_ud = stable_nxt[1] & stable_nxt[3];
    assign strobe  = (press | rpt_hit) & ~{1'b0, lock_ud, lock_lr, lock_ud, lock_lr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {btns_v, btnu_v, btnr_v, btnd_v, btnl_v} <= '0;
        end else begin
            {btns_v, btnu_v, btnr_v, btnd_v, btnl_v} <= strobe;
        end
    end

    assign btn_held = stable;

endmodule
